// File: rtl/clk_en_gen_m.sv
// Multi-channel fractional clock-enable generator: per channel, ce pulses num times every den stepped edges.
// Latency: ce/sq are registered; a config write or sync is applied at its sampling edge, stepping resumes on the next edge.
// Backpressure: none; cfg_we is a fire-and-forget strobe and run gates stepping globally.
module clk_en_gen_m #(
    parameter int NUM_CH  = 2,
    parameter int ACC_W   = 20,
    parameter int DEF_NUM = 1,
    parameter int DEF_DEN = 12,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              sync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_num,
    input  logic [ACC_W-1:0]  cfg_den,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] sq,
    output logic [NUM_CH-1:0] cfg_err
);

    // Per-channel ratio and phase state
    logic [ACC_W-1:0]  num_q [NUM_CH];
    logic [ACC_W-1:0]  num_d [NUM_CH];
    logic [ACC_W-1:0]  den_q [NUM_CH];
    logic [ACC_W-1:0]  den_d [NUM_CH];
    logic [ACC_W-1:0]  acc_q [NUM_CH];
    logic [ACC_W-1:0]  acc_d [NUM_CH];
    logic [NUM_CH-1:0] valid_q;
    logic [NUM_CH-1:0] valid_d;
    logic [NUM_CH-1:0] ce_q;
    logic [NUM_CH-1:0] ce_d;
    logic [NUM_CH-1:0] sq_q;
    logic [NUM_CH-1:0] sq_d;

    // Datapath helpers
    logic [ACC_W:0]    sum [NUM_CH];
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] sel;
    logic              cfg_ok;

    // Decode the config strobe: addressed channel (out-of-range addresses match nothing) and ratio legality
    always_comb begin
        cfg_ok = (cfg_num != '0) && (cfg_num <= cfg_den);
        sel    = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            sel[ch] = cfg_we && (cfg_ch == CH_W'(ch));
        end
    end

    // Accumulate with one guard bit so acc + num never overflows before the wrap compare
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            sum[ch]  = {1'b0, acc_q[ch]} + {1'b0, num_q[ch]};
            wrap[ch] = (sum[ch] >= {1'b0, den_q[ch]});
        end
    end

    // Next state per channel, highest priority first: addressed config write, sync, step, hold
    always_comb begin
        num_d   = num_q;
        den_d   = den_q;
        acc_d   = acc_q;
        valid_d = valid_q;
        ce_d    = '0;
        sq_d    = sq_q;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (sel[ch]) begin
                num_d[ch]   = cfg_num;
                den_d[ch]   = cfg_den;
                acc_d[ch]   = '0;
                valid_d[ch] = cfg_ok;
                sq_d[ch]    = 1'b0;
            end else if (sync) begin
                acc_d[ch] = '0;
                sq_d[ch]  = 1'b0;
            end else if (run && valid_q[ch]) begin
                if (wrap[ch]) begin
                    // acc < den and num <= den, so the wrapped value fits in ACC_W bits exactly
                    acc_d[ch] = acc_q[ch] + num_q[ch] - den_q[ch];
                    ce_d[ch]  = 1'b1;
                    sq_d[ch]  = ~sq_q[ch];
                end else begin
                    acc_d[ch] = sum[ch][ACC_W-1:0];
                end
            end
        end
    end

    // State registers; reset restores the legacy default ratio on every channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                num_q[ch] <= ACC_W'(DEF_NUM);
                den_q[ch] <= ACC_W'(DEF_DEN);
                acc_q[ch] <= '0;
            end
            valid_q <= '1;
            ce_q    <= '0;
            sq_q    <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                num_q[ch] <= num_d[ch];
                den_q[ch] <= den_d[ch];
                acc_q[ch] <= acc_d[ch];
            end
            valid_q <= valid_d;
            ce_q    <= ce_d;
            sq_q    <= sq_d;
        end
    end

    // The error flag is simply the registered complement of the valid flag
    assign ce      = ce_q;
    assign sq      = sq_q;
    assign cfg_err = ~valid_q;

endmodule

// File: tb/tb_clk_en_gen_m.sv
// Self-checking bench for clk_en_gen_m with two channels and a pulse-count reference model.
// Model: pulses after n stepped edges since the last phase clear = floor(n*num/den); ce marks an increment.
// All inputs are driven 1 time unit after the rising edge and outputs are sampled there too.
module tb_clk_en_gen_m;

    localparam int NUM_CH = 2;
    localparam int ACC_W  = 20;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              run = 1'b1;
    logic              sync = 1'b0;
    logic              cfg_we = 1'b0;
    logic [0:0]        cfg_ch = '0;
    logic [ACC_W-1:0]  cfg_num = '0;
    logic [ACC_W-1:0]  cfg_den = '0;
    logic [NUM_CH-1:0] ce;
    logic [NUM_CH-1:0] sq;
    logic [NUM_CH-1:0] cfg_err;

    int cmp_cnt  = 0;
    int fail_cnt = 0;

    // Reference model state
    longint            m_n   [NUM_CH];
    longint            m_num [NUM_CH];
    longint            m_den [NUM_CH];
    logic [NUM_CH-1:0] m_valid;
    logic [NUM_CH-1:0] m_ce;
    logic [NUM_CH-1:0] m_sq;

    clk_en_gen_m #(
        .NUM_CH (NUM_CH),
        .ACC_W  (ACC_W),
        .DEF_NUM(1),
        .DEF_DEN(12)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run),
        .sync   (sync),
        .cfg_we (cfg_we),
        .cfg_ch (cfg_ch),
        .cfg_num(cfg_num),
        .cfg_den(cfg_den),
        .ce     (ce),
        .sq     (sq),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_n[c]   = 0;
            m_num[c] = 1;
            m_den[c] = 12;
        end
        m_valid = '1;
        m_ce    = '0;
        m_sq    = '0;
    endtask

    // Advance one clock edge and update the model from the inputs sampled at that edge
    task automatic tick();
        longint p_now, p_prev;
        @(posedge clk);
        for (int c = 0; c < NUM_CH; c++) begin
            if (!rst_n) begin
                m_n[c] = 0; m_num[c] = 1; m_den[c] = 12;
                m_valid[c] = 1'b1; m_ce[c] = 1'b0; m_sq[c] = 1'b0;
            end else if (cfg_we && (int'(cfg_ch) == c)) begin
                m_num[c]   = longint'(cfg_num);
                m_den[c]   = longint'(cfg_den);
                m_n[c]     = 0;
                m_valid[c] = (cfg_num != 0) && (cfg_num <= cfg_den);
                m_ce[c]    = 1'b0;
                m_sq[c]    = 1'b0;
            end else if (sync) begin
                m_n[c]  = 0;
                m_ce[c] = 1'b0;
                m_sq[c] = 1'b0;
            end else if (run && m_valid[c]) begin
                m_n[c]  = m_n[c] + 1;
                p_now   = (m_n[c] * m_num[c]) / m_den[c];
                p_prev  = ((m_n[c] - 1) * m_num[c]) / m_den[c];
                m_ce[c] = (p_now != p_prev);
                m_sq[c] = ((p_now % 2) != 0);
            end else begin
                m_ce[c] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic write_cfg(input int ch, input int num, input int den);
        cfg_we  = 1'b1;
        cfg_ch  = 1'(ch);
        cfg_num = ACC_W'(num);
        cfg_den = ACC_W'(den);
        tick();
        cfg_we  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        run   = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            cmp_cnt++;
            if ({ce, sq, cfg_err} !== '0) begin
                fail_cnt++;
                $display("FAIL reset_hold cyc %0d: ce/sq/err got %b/%b/%b want all zero", i, ce, sq, cfg_err);
            end
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 48; e++) begin
            tick();
            cmp_cnt++;
            if ({ce, sq, cfg_err} !== {m_ce, m_sq, ~m_valid}) begin
                fail_cnt++;
                $display("FAIL default_model edge %0d: ce/sq/err got %b/%b/%b want %b/%b/%b", e, ce, sq, cfg_err, m_ce, m_sq, ~m_valid);
            end
            cmp_cnt++;
            if (ce[0] !== ((e % 12) == 0) || sq[0] !== (((e / 12) % 2) == 1)) begin
                fail_cnt++;
                $display("FAIL default_div24 edge %0d: ce0/sq0 got %b/%b want %b/%b", e, ce[0], sq[0], (e % 12) == 0, ((e / 12) % 2) == 1);
            end
        end
    endtask

    task automatic test_fractional();
        logic [15:0] pat;
        int          pulses;
        pat    = 16'hA528;  // ce high after edges 3,5,8,10,13,15
        pulses = 0;
        write_cfg(1, 2, 5);
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (ce[1]) pulses++;
            cmp_cnt++;
            if ({ce, sq, cfg_err} !== {m_ce, m_sq, ~m_valid}) begin
                fail_cnt++;
                $display("FAIL frac_model edge %0d: ce/sq/err got %b/%b/%b want %b/%b/%b", e, ce, sq, cfg_err, m_ce, m_sq, ~m_valid);
            end
            if (e <= 15) begin
                cmp_cnt++;
                if (ce[1] !== pat[e]) begin
                    fail_cnt++;
                    $display("FAIL frac_2_5 edge %0d: ce1 got %b want %b", e, ce[1], pat[e]);
                end
            end
        end
        cmp_cnt++;
        if (pulses != 12) begin
            fail_cnt++;
            $display("FAIL frac_count: got %0d pulses want 12 in 30 edges", pulses);
        end
    endtask

    task automatic test_gameboy();
        int     last, pulses, gap;
        longint want;
        last   = 0;
        pulses = 0;
        write_cfg(0, 16384, 390625);
        for (int e = 1; e <= 20000; e++) begin
            tick();
            cmp_cnt++;
            if ({ce, sq, cfg_err} !== {m_ce, m_sq, ~m_valid}) begin
                fail_cnt++;
                $display("FAIL gb_model edge %0d: ce/sq/err got %b/%b/%b want %b/%b/%b", e, ce, sq, cfg_err, m_ce, m_sq, ~m_valid);
            end
            if (ce[0]) begin
                pulses++;
                gap = e - last;
                last = e;
                cmp_cnt++;
                if (gap != 23 && gap != 24) begin
                    fail_cnt++;
                    $display("FAIL gb_spacing edge %0d: got gap %0d want 23 or 24", e, gap);
                end
            end
        end
        want = (64'd20000 * 64'd16384) / 64'd390625;
        cmp_cnt++;
        if (longint'(pulses) != want) begin
            fail_cnt++;
            $display("FAIL gb_count: got %0d pulses want %0d", pulses, want);
        end
    endtask

    task automatic test_edge_ratios();
        write_cfg(0, 7, 7);
        for (int e = 1; e <= 10; e++) begin
            tick();
            cmp_cnt++;
            if (ce[0] !== 1'b1 || sq[0] !== ((e % 2) == 1)) begin
                fail_cnt++;
                $display("FAIL full_rate edge %0d: ce0/sq0 got %b/%b want 1/%b", e, ce[0], sq[0], (e % 2) == 1);
            end
        end
        write_cfg(0, 2, 5);
        for (int i = 0; i < 3; i++) tick();
        write_cfg(1, 6, 5);
        for (int e = 1; e <= 20; e++) begin
            tick();
            cmp_cnt++;
            if ({ce, sq, cfg_err} !== {m_ce, m_sq, ~m_valid}) begin
                fail_cnt++;
                $display("FAIL bad_cfg_model edge %0d: ce/sq/err got %b/%b/%b want %b/%b/%b", e, ce, sq, cfg_err, m_ce, m_sq, ~m_valid);
            end
            cmp_cnt++;
            if (cfg_err[1] !== 1'b1 || ce[1] !== 1'b0) begin
                fail_cnt++;
                $display("FAIL bad_cfg edge %0d: err1/ce1 got %b/%b want 1/0", e, cfg_err[1], ce[1]);
            end
        end
        write_cfg(1, 1, 3);
        cmp_cnt++;
        if (cfg_err[1] !== 1'b0) begin
            fail_cnt++;
            $display("FAIL err_clear: err1 got %b want 0", cfg_err[1]);
        end
        for (int e = 1; e <= 12; e++) begin
            tick();
            cmp_cnt++;
            if (ce[1] !== ((e % 3) == 0)) begin
                fail_cnt++;
                $display("FAIL recover_1_3 edge %0d: ce1 got %b want %b", e, ce[1], (e % 3) == 0);
            end
        end
    endtask

    task automatic test_run_gap();
        run = 1'b1;
        write_cfg(0, 1, 12);
        for (int e = 1; e <= 20; e++) begin
            run = !(e >= 6 && e <= 8);
            tick();
            cmp_cnt++;
            if ({ce, sq, cfg_err} !== {m_ce, m_sq, ~m_valid}) begin
                fail_cnt++;
                $display("FAIL gap_model edge %0d: ce/sq/err got %b/%b/%b want %b/%b/%b", e, ce, sq, cfg_err, m_ce, m_sq, ~m_valid);
            end
            cmp_cnt++;
            if (ce[0] !== (e == 15)) begin
                fail_cnt++;
                $display("FAIL run_gap edge %0d: ce0 got %b want %b", e, ce[0], e == 15);
            end
        end
        run = 1'b1;
    endtask

    task automatic test_sync();
        write_cfg(0, 1, 4);
        tick();
        write_cfg(1, 1, 4);
        for (int i = 0; i < 6; i++) tick();
        sync = 1'b1;
        tick();
        sync = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            cmp_cnt++;
            if (ce[0] !== ((e % 4) == 0) || ce[1] !== ((e % 4) == 0)) begin
                fail_cnt++;
                $display("FAIL sync_align edge %0d: ce got %b want both %b", e, ce, (e % 4) == 0);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            run     = ($urandom_range(0, 9) != 0);
            sync    = ($urandom_range(0, 49) == 0);
            cfg_we  = ($urandom_range(0, 19) == 0);
            cfg_ch  = 1'($urandom_range(0, 1));
            cfg_den = ACC_W'($urandom_range(1, 16));
            cfg_num = ACC_W'($urandom_range(0, 18));
            tick();
            cmp_cnt++;
            if ({ce, sq, cfg_err} !== {m_ce, m_sq, ~m_valid}) begin
                fail_cnt++;
                $display("FAIL random cyc %0d: ce/sq/err got %b/%b/%b want %b/%b/%b", i, ce, sq, cfg_err, m_ce, m_sq, ~m_valid);
            end
        end
        run    = 1'b1;
        sync   = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic test_async_reset();
        write_cfg(0, 7, 7);
        write_cfg(1, 6, 5);
        tick();
        cmp_cnt++;
        if (ce[0] !== 1'b1 || cfg_err[1] !== 1'b1) begin
            fail_cnt++;
            $display("FAIL pre_reset: ce0/err1 got %b/%b want 1/1", ce[0], cfg_err[1]);
        end
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        cmp_cnt++;
        if (ce !== '0) begin
            fail_cnt++;
            $display("FAIL async_ce: got %b want 00", ce);
        end
        cmp_cnt++;
        if (sq !== '0) begin
            fail_cnt++;
            $display("FAIL async_sq: got %b want 00", sq);
        end
        cmp_cnt++;
        if (cfg_err !== '0) begin
            fail_cnt++;
            $display("FAIL async_err: got %b want 00", cfg_err);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            tick();
            cmp_cnt++;
            if ({ce, sq, cfg_err} !== {m_ce, m_sq, ~m_valid}) begin
                fail_cnt++;
                $display("FAIL post_reset edge %0d: ce/sq/err got %b/%b/%b want %b/%b/%b", e, ce, sq, cfg_err, m_ce, m_sq, ~m_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fractional();
        test_gameboy();
        test_edge_ratios();
        test_run_gap();
        test_sync();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
